// File: rtl/bp_me_cache_dma_to_cce_pkg.sv
// BedRock memory message and bsg_cache DMA packet types seen by the L2 DMA-to-CCE bridge.
package bp_me_cache_dma_to_cce_pkg;

  localparam int PADDR_W   = 40;
  localparam int LCE_ID_W  = 4;
  localparam int L2_DATA_W = 64;
  localparam int BLOCK_W   = 512;

  typedef enum logic [3:0] {
    e_bedrock_mem_rd    = 4'd0,
    e_bedrock_mem_wr    = 4'd1,
    e_bedrock_mem_uc_rd = 4'd2,
    e_bedrock_mem_uc_wr = 4'd3,
    e_bedrock_mem_pre   = 4'd4,
    e_bedrock_mem_amo   = 4'd5
  } bp_bedrock_mem_type_e;

  typedef enum logic [3:0] {
    e_bedrock_store   = 4'd0,
    e_bedrock_amoswap = 4'd1,
    e_bedrock_amoadd  = 4'd2
  } bp_bedrock_wr_subop_e;

  typedef enum logic [2:0] {
    e_bedrock_msg_size_1  = 3'd0,
    e_bedrock_msg_size_2  = 3'd1,
    e_bedrock_msg_size_4  = 3'd2,
    e_bedrock_msg_size_8  = 3'd3,
    e_bedrock_msg_size_16 = 3'd4,
    e_bedrock_msg_size_32 = 3'd5,
    e_bedrock_msg_size_64 = 3'd6
  } bp_bedrock_msg_size_e;

  typedef struct packed {
    logic [LCE_ID_W-1:0] lce_id;
  } bp_bedrock_mem_payload_s;

  typedef struct packed {
    bp_bedrock_mem_payload_s payload;
    bp_bedrock_msg_size_e    size;
    logic [PADDR_W-1:0]      addr;
    bp_bedrock_wr_subop_e    subop;
    bp_bedrock_mem_type_e    msg_type;
  } bp_bedrock_mem_header_s;

  typedef struct packed {
    logic [BLOCK_W-1:0]     data;
    bp_bedrock_mem_header_s header;
  } bp_bedrock_mem_msg_s;

  typedef struct packed {
    logic               write_not_read;
    logic [PADDR_W-1:0] addr;
  } bsg_cache_dma_pkt_s;

endpackage

// File: rtl/bp_me_cache_dma_to_cce.sv
// Turns L2 DMA fill/evict packets into full-block BedRock mem commands, one transaction in flight.
// Evict words are gathered into a block buffer; fill blocks are scattered back one 64-bit word at a time.
module bp_me_cache_dma_to_cce
  import bp_me_cache_dma_to_cce_pkg::*;
#(
  parameter logic [LCE_ID_W-1:0] lce_id_p = '0
) (
  input  logic                   clk_i,
  input  logic                   reset_n_i,
  input  bsg_cache_dma_pkt_s     dma_pkt_i,
  input  logic                   dma_pkt_v_i,
  output logic                   dma_pkt_yumi_o,
  output logic [L2_DATA_W-1:0]   dma_data_o,
  output logic                   dma_data_v_o,
  input  logic                   dma_data_ready_i,
  input  logic [L2_DATA_W-1:0]   dma_data_i,
  input  logic                   dma_data_v_i,
  output logic                   dma_data_yumi_o,
  output bp_bedrock_mem_msg_s    mem_cmd_o,
  output logic                   mem_cmd_v_o,
  input  logic                   mem_cmd_ready_and_i,
  input  bp_bedrock_mem_msg_s    mem_resp_i,
  input  logic                   mem_resp_v_i,
  output logic                   mem_resp_yumi_o
);

  localparam int         WORDS     = BLOCK_W / L2_DATA_W;
  localparam logic [2:0] LAST_WORD = 3'(WORDS - 1);

  typedef enum logic [2:0] {S_IDLE, S_GATHER, S_SEND, S_WAIT, S_SCATTER} state_e;

  state_e               r_state, w_state_nxt;
  logic [2:0]           r_wc, w_wc_nxt;
  logic [PADDR_W-1:0]   r_addr, w_addr_nxt;
  logic                 r_wnr, w_wnr_nxt;
  logic [BLOCK_W-1:0]   r_buf;
  logic                 w_buf_word_we, w_buf_blk_we;
  logic                 w_unused;

  assign w_unused = ^{dma_pkt_i.addr[5:0], mem_resp_i.header};

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state <= S_IDLE;
      r_wc    <= '0;
      r_addr  <= '0;
      r_wnr   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_wc    <= w_wc_nxt;
      r_addr  <= w_addr_nxt;
      r_wnr   <= w_wnr_nxt;
    end
  end

  // Block buffer carries no reset: every path fully overwrites it before it is read.
  always_ff @(posedge clk_i) begin
    if (w_buf_blk_we)
      r_buf <= mem_resp_i.data;
    else if (w_buf_word_we)
      r_buf[{r_wc, 6'b0} +: L2_DATA_W] <= dma_data_i;
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_wc_nxt        = r_wc;
    w_addr_nxt      = r_addr;
    w_wnr_nxt       = r_wnr;
    w_buf_word_we   = 1'b0;
    w_buf_blk_we    = 1'b0;
    dma_pkt_yumi_o  = 1'b0;
    dma_data_yumi_o = 1'b0;
    dma_data_v_o    = 1'b0;
    dma_data_o      = '0;
    mem_cmd_v_o     = 1'b0;
    mem_cmd_o       = '0;
    mem_resp_yumi_o = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        dma_pkt_yumi_o = dma_pkt_v_i;
        if (dma_pkt_v_i) begin
          w_addr_nxt  = {dma_pkt_i.addr[PADDR_W-1:6], 6'b0};
          w_wnr_nxt   = dma_pkt_i.write_not_read;
          w_wc_nxt    = '0;
          w_state_nxt = dma_pkt_i.write_not_read ? S_GATHER : S_SEND;
        end
      end
      S_GATHER: begin
        dma_data_yumi_o = dma_data_v_i;
        if (dma_data_v_i) begin
          w_buf_word_we = 1'b1;
          w_wc_nxt      = r_wc + 3'd1;
          if (r_wc == LAST_WORD)
            w_state_nxt = S_SEND;
        end
      end
      S_SEND: begin
        mem_cmd_v_o                       = 1'b1;
        mem_cmd_o.header.msg_type         = r_wnr ? e_bedrock_mem_wr : e_bedrock_mem_rd;
        mem_cmd_o.header.subop            = e_bedrock_store;
        mem_cmd_o.header.size             = e_bedrock_msg_size_64;
        mem_cmd_o.header.addr             = r_addr;
        mem_cmd_o.header.payload.lce_id   = lce_id_p;
        mem_cmd_o.data                    = r_wnr ? r_buf : '0;
        if (mem_cmd_ready_and_i)
          w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        mem_resp_yumi_o = mem_resp_v_i;
        if (mem_resp_v_i) begin
          if (r_wnr) begin
            w_state_nxt = S_IDLE;
          end else begin
            w_buf_blk_we = 1'b1;
            w_wc_nxt     = '0;
            w_state_nxt  = S_SCATTER;
          end
        end
      end
      S_SCATTER: begin
        dma_data_v_o = 1'b1;
        dma_data_o   = r_buf[{r_wc, 6'b0} +: L2_DATA_W];
        if (dma_data_ready_i) begin
          w_wc_nxt = r_wc + 3'd1;
          if (r_wc == LAST_WORD)
            w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

`ifndef SYNTHESIS
  a_resp_type: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    (r_state == S_WAIT && mem_resp_v_i) |->
      (mem_resp_i.header.msg_type == (r_wnr ? e_bedrock_mem_wr : e_bedrock_mem_rd)))
    else $error("mem_resp msg_type does not match outstanding command");
  a_resp_size: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    (r_state == S_WAIT && mem_resp_v_i) |-> (mem_resp_i.header.size == e_bedrock_msg_size_64))
    else $error("mem_resp size is not a full block");
  a_stray_evict: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    dma_data_v_i |-> (r_state == S_GATHER))
    else $warning("evict data valid outside gather; ignored");
`endif

endmodule

// File: tb/tb_bp_me_cache_dma_to_cce.sv
// Scoreboard bench for the DMA-to-CCE bridge: reads, writes, backpressure, early response, mid-fill reset.
module tb_bp_me_cache_dma_to_cce;
  import bp_me_cache_dma_to_cce_pkg::*;

  localparam logic [LCE_ID_W-1:0] LCE_ID = 4'h5;

  logic                 clk = 1'b0;
  logic                 rst_n;
  bsg_cache_dma_pkt_s   pkt;
  logic                 pkt_v, pkt_yumi;
  logic [63:0]          dma_dout, dma_din;
  logic                 dma_dout_v, dma_dout_rdy, dma_din_v, dma_din_yumi;
  bp_bedrock_mem_msg_s  cmd, resp;
  logic                 cmd_v, cmd_rdy, resp_v, resp_yumi;

  int                   total = 0;
  int                   bad = 0;
  logic [63:0]          sbq[$];

  always #5 clk = ~clk;

  bp_me_cache_dma_to_cce #(.lce_id_p(LCE_ID)) dut (
    .clk_i(clk), .reset_n_i(rst_n),
    .dma_pkt_i(pkt), .dma_pkt_v_i(pkt_v), .dma_pkt_yumi_o(pkt_yumi),
    .dma_data_o(dma_dout), .dma_data_v_o(dma_dout_v), .dma_data_ready_i(dma_dout_rdy),
    .dma_data_i(dma_din), .dma_data_v_i(dma_din_v), .dma_data_yumi_o(dma_din_yumi),
    .mem_cmd_o(cmd), .mem_cmd_v_o(cmd_v), .mem_cmd_ready_and_i(cmd_rdy),
    .mem_resp_i(resp), .mem_resp_v_i(resp_v), .mem_resp_yumi_o(resp_yumi)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_pkt_yumi"}, pkt_yumi, 0);
    chk({tag, "_data_v"}, dma_dout_v, 0);
    chk({tag, "_data"}, dma_dout, 0);
    chk({tag, "_evict_yumi"}, dma_din_yumi, 0);
    chk({tag, "_cmd_v"}, cmd_v, 0);
    chk({tag, "_cmd_addr"}, cmd.header.addr, 0);
    chk({tag, "_resp_yumi"}, resp_yumi, 0);
  endtask

  // Entered and left at a negedge with the DUT idle.
  task automatic do_read(input logic [39:0] a, input logic [63:0] base, input int stall,
                         input bit early, input bit tog, input int abort_at);
    int n, budget;
    bit rdy, aborted;
    logic [63:0] w;
    pkt.write_not_read = 1'b0; pkt.addr = a; pkt_v = 1'b1;
    #1 chk("rd_pkt_yumi", pkt_yumi, 1);
    @(negedge clk);
    pkt_v = 1'b0; pkt = '0;
    resp = '0;
    resp.header.msg_type = e_bedrock_mem_rd;
    resp.header.size     = e_bedrock_msg_size_64;
    resp.header.addr     = {a[39:6], 6'b0};
    for (int i = 0; i < 8; i++) resp.data[i*64 +: 64] = base + 64'(i);
    if (early) begin
      resp_v = 1'b1;
      for (int i = 0; i < 8; i++) sbq.push_back(base + 64'(i));
      #1;
    end
    for (int k = 0; k <= stall; k++) begin
      if (k > 0) @(negedge clk);
      chk("rd_cmd_v", cmd_v, 1);
      chk("rd_cmd_addr", cmd.header.addr, {a[39:6], 6'b0});
      chk("rd_cmd_type", cmd.header.msg_type, e_bedrock_mem_rd);
      chk("rd_cmd_size", cmd.header.size, e_bedrock_msg_size_64);
      chk("rd_cmd_lce", cmd.header.payload.lce_id, LCE_ID);
      chk("rd_cmd_data_zero", |cmd.data, 0);
      chk("rd_resp_not_early", resp_yumi, 0);
    end
    cmd_rdy = 1'b1;
    @(negedge clk);
    cmd_rdy = 1'b0;
    chk("rd_wait_cmd_v", cmd_v, 0);
    if (!early) begin
      resp_v = 1'b1;
      for (int i = 0; i < 8; i++) sbq.push_back(base + 64'(i));
      #1;
    end
    chk("rd_resp_yumi", resp_yumi, 1);
    @(negedge clk);
    resp_v = 1'b0; resp = '0;
    chk("rd_first_data_v", dma_dout_v, 1);
    n = 0; budget = 0; aborted = 1'b0;
    while (n < 8 && budget < 40) begin
      budget++;
      if (abort_at >= 0 && n == abort_at) begin
        rst_n = 1'b0;
        #1 chk_idle("abort");
        sbq.delete();
        aborted = 1'b1;
        break;
      end
      rdy = tog ? (budget % 2 == 1) : 1'b1;
      dma_dout_rdy = rdy;
      chk("rd_data_v", dma_dout_v, 1);
      if (sbq.size() == 0) chk("rd_sb_empty", sbq.size(), 1);
      else if (rdy) begin
        w = sbq.pop_front();
        chk("rd_word", dma_dout, w);
        n++;
      end else chk("rd_word_hold", dma_dout, sbq[0]);
      @(negedge clk);
    end
    dma_dout_rdy = 1'b0;
    if (aborted) begin
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk_idle("post_abort");
    end else begin
      chk("rd_word_count", n, 8);
      chk("rd_done_data_v", dma_dout_v, 0);
    end
  endtask

  task automatic do_write(input logic [39:0] a, input logic [63:0] base, input int stall);
    int n, k;
    logic [63:0] exp_blk [8];
    pkt.write_not_read = 1'b1; pkt.addr = a; pkt_v = 1'b1;
    #1 chk("wr_pkt_yumi", pkt_yumi, 1);
    @(negedge clk);
    pkt_v = 1'b0; pkt = '0;
    n = 0; k = 0;
    while (n < 8 && k < 20) begin
      k++;
      if (k == 3) begin
        dma_din_v = 1'b0;
        #1 chk("wr_bubble_yumi", dma_din_yumi, 0);
      end else begin
        dma_din = base + 64'(n); dma_din_v = 1'b1;
        sbq.push_back(base + 64'(n));
        n++;
        #1 chk("wr_evict_yumi", dma_din_yumi, 1);
      end
      chk("wr_gather_no_cmd", cmd_v, 0);
      @(negedge clk);
    end
    dma_din_v = 1'b0; dma_din = '0;
    for (int i = 0; i < 8; i++) exp_blk[i] = (sbq.size() != 0) ? sbq.pop_front() : 64'hx;
    for (int s = 0; s <= stall; s++) begin
      if (s > 0) @(negedge clk);
      chk("wr_cmd_v", cmd_v, 1);
      chk("wr_cmd_type", cmd.header.msg_type, e_bedrock_mem_wr);
      chk("wr_cmd_addr", cmd.header.addr, {a[39:6], 6'b0});
      chk("wr_cmd_size", cmd.header.size, e_bedrock_msg_size_64);
      chk("wr_cmd_lce", cmd.header.payload.lce_id, LCE_ID);
      for (int i = 0; i < 8; i++) chk("wr_cmd_word", cmd.data[i*64 +: 64], exp_blk[i]);
    end
    cmd_rdy = 1'b1;
    @(negedge clk);
    cmd_rdy = 1'b0;
    resp = '0;
    resp.header.msg_type = e_bedrock_mem_wr;
    resp.header.size     = e_bedrock_msg_size_64;
    resp.data            = {8{64'hDEAD_BEEF_0BAD_F00D}};
    resp_v = 1'b1;
    pkt.write_not_read = 1'b0; pkt.addr = 40'h80_0000_5000; pkt_v = 1'b1;
    #1;
    chk("wr_resp_yumi", resp_yumi, 1);
    chk("wr_wait_pkt_yumi", pkt_yumi, 0);
    chk("wr_wait_cmd_v", cmd_v, 0);
    @(negedge clk);
    resp_v = 1'b0; resp = '0;
    chk("wr_next_pkt_yumi", pkt_yumi, 1);
    chk("wr_idle_data_v", dma_dout_v, 0);
    pkt_v = 1'b0; pkt = '0;
  endtask

  initial begin
    rst_n = 1'b0; pkt = '0; pkt_v = 1'b0; dma_dout_rdy = 1'b0; dma_din = '0; dma_din_v = 1'b0;
    cmd_rdy = 1'b0; resp = '0; resp_v = 1'b0;
    repeat (3) @(negedge clk);
    chk_idle("rst_hold");
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_idle("post_rst");
    end
    resp_v = 1'b1;
    #1 chk("idle_no_unsolicited", resp_yumi, 0);
    resp_v = 1'b0;
    @(negedge clk);

    do_read(40'h80_8000_1234, 64'h0, 0, 1'b0, 1'b0, -1);
    do_write(40'h80_8000_0040, 64'hA0, 0);
    do_read(40'h80_8000_2000, 64'h100, 5, 1'b0, 1'b1, -1);
    do_read(40'h80_8000_2fc8, 64'h200, 2, 1'b1, 1'b0, -1);
    do_write(40'h80_8000_7fff, 64'hB000, 5);
    do_read(40'h80_8000_3000, 64'h300, 0, 1'b0, 1'b0, 3);
    do_read(40'h80_8000_3000, 64'h400, 0, 1'b0, 1'b1, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

endmodule
